spi_des_fifo: RTL and testbench

//   Parametrised SPI slave receiver, successor to the single-word deserialiser.

---
 rtl/spi_des_fifo.sv | 163 ++++++++++++++++
 tb/tb_spi_des_fifo.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_des_fifo.sv
// SPI slave receiver: oversamples the SPI pins on clk, assembles DATA_W-bit
// words in any CPOL/CPHA mode and bit order, and queues completed words in a
// small output FIFO with a valid/ready interface. Several words may arrive in
// one chip-select frame; a frame that ends mid-word raises frame_err.
module spi_des_fifo #(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sclk,
  input  logic                        cs_n,
  input  logic                        sdi,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        frame_err,
  input  logic                        clr_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_s, cs_s, sdi_s;
  logic                   lead_edge, trail_edge, sample_edge, cs_fall, cs_rise;

  state_t                 state, state_next;
  logic                   start, abort, shift_en, word_done;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_W-1:0]      sr, sr_next;

  logic [DATA_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic                   pop, push_ok, drop;

  // Synchronise the asynchronous pins and keep one extra synced sample for edge detection.
  // NOTE: every flop is assigned with <= so all registers update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '1;
      sdi_sync  <= '0;
      sclk_prev <= CPOL;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign sdi_s       = sdi_sync[SYNC_STAGES-1];
  assign lead_edge   = (sclk_prev == CPOL) && (sclk_s != CPOL);
  assign trail_edge  = (sclk_prev != CPOL) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign cs_fall     = cs_prev && !cs_s;
  assign cs_rise     = !cs_prev && cs_s;

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and per-cycle control strobes; a deselect outranks a coincident sample edge.
  // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    abort      = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = SHIFT;
          start      = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else if (sample_edge) begin
          shift_en = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign word_done = shift_en && (bit_cnt == LAST_BIT);
  assign sr_next   = MSB_FIRST ? {sr[DATA_W-2:0], sdi_s} : {sdi_s, sr[DATA_W-1:1]};

  // Shift register and bit counter; the counter wraps on each completed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      sr      <= '0;
    end else if (start) begin
      bit_cnt <= '0;
      sr      <= '0;
    end else if (abort) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      sr      <= sr_next;
      bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
    end
  end

  // Partial-word deselect pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= abort && (bit_cnt != '0);
  end

  assign m_valid = (fifo_count != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;
  assign pop     = m_valid && m_ready;
  assign push_ok = word_done && ((fifo_count != FULL_COUNT) || pop);
  assign drop    = word_done && (fifo_count == FULL_COUNT) && !pop;

  // FIFO storage write.
  // NOTE: storage is not reset; the count gates m_data, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= sr_next;
  end

  // FIFO pointers, occupancy and sticky overflow; pointers wrap naturally at a power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      overflow <= (overflow && !clr_err) || drop;
    end
  end

endmodule

// File: tb/tb_spi_des_fifo.sv
// Bench for spi_des_fifo: a main MSB-first mode-0 instance checked every cycle
// against a queue-based model, plus four LSB-first instances covering the
// CPOL/CPHA modes, checked on the words they deliver.
module tb_spi_des_fifo;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n, sclk, cs_n, cs_m, sdi, m_ready, clr_err;
  logic m_valid, overflow, frame_err;
  logic [31:0] m_data;
  logic [2:0]  fifo_count;

  logic        mv [4];
  logic [31:0] md [4];
  logic [2:0]  mc [4];
  logic        mo [4];
  logic        mf [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_des_fifo #(.DATA_W(32), .FIFO_DEPTH(4), .SYNC_STAGES(S),
                 .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .sdi(sdi),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err),
    .clr_err(clr_err));

  // Mode instance g: CPOL = g[1], CPHA = g[0]; all LSB-first, always ready.
  for (genvar g = 0; g < 4; g++) begin : g_mode
    localparam bit POL = ((g / 2) == 1);
    localparam bit PHA = ((g % 2) == 1);
    spi_des_fifo #(.DATA_W(32), .FIFO_DEPTH(4), .SYNC_STAGES(S),
                   .CPOL(POL), .CPHA(PHA), .MSB_FIRST(1'b0)) mode_dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk ^ POL), .cs_n(cs_m), .sdi(sdi),
      .m_valid(mv[g]), .m_ready(1'b1), .m_data(md[g]),
      .fifo_count(mc[g]), .overflow(mo[g]), .frame_err(mf[g]),
      .clr_err(1'b0));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural model (main instance) ----------------
  // Pin history: the design sees each pin S samples late and detects edges
  // between consecutive delayed samples. Words are kept as a plain queue.
  bit          sclk_log[$], cs_log[$], sdi_log[$];
  logic [31:0] exp_q[$];
  logic [31:0] mword;
  int          nbits;
  bit          m_ovf, m_ferr;

  function automatic void model_reset();
    sclk_log.delete(); cs_log.delete(); sdi_log.delete();
    for (int i = 0; i <= S; i++) begin
      sclk_log.push_back(1'b0);
      cs_log.push_back(1'b1);
      sdi_log.push_back(1'b0);
    end
    exp_q.delete();
    mword = '0; nbits = 0; m_ovf = 1'b0; m_ferr = 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit s_prv, s_syn, c_prv, c_syn, d_syn, do_pop, do_push, full, drop;
    if (!rst_n) begin
      model_reset();
    end else begin
      s_prv = sclk_log[0]; s_syn = sclk_log[1];
      c_prv = cs_log[0];   c_syn = cs_log[1];
      d_syn = sdi_log[1];
      do_pop  = (exp_q.size() != 0) && m_ready;
      do_push = 1'b0;
      drop    = 1'b0;
      m_ferr  = 1'b0;
      if (c_prv && !c_syn) begin
        nbits = 0; mword = '0;
      end else if (!c_prv && c_syn) begin
        if (nbits != 0) m_ferr = 1'b1;
        nbits = 0;
      end else if (!c_prv && !s_prv && s_syn) begin
        mword = {mword[30:0], d_syn};
        nbits++;
        if (nbits == 32) begin
          do_push = 1'b1;
          nbits = 0;
        end
      end
      full = (exp_q.size() == 4);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        if (!full || do_pop) exp_q.push_back(mword);
        else drop = 1'b1;
      end
      m_ovf = (m_ovf && !clr_err) || drop;
      sclk_log.push_back(sclk); void'(sclk_log.pop_front());
      cs_log.push_back(cs_n);   void'(cs_log.pop_front());
      sdi_log.push_back(sdi);   void'(sdi_log.pop_front());
    end
  end

  // ---------------- per-cycle compare and monitors ----------------
  int          ferr_pulses = 0;
  logic [31:0] popped[$];
  int          mode_cnt [4] = '{default: 0};
  logic [31:0] mode_word [4] = '{default: '0};

  always @(negedge clk) begin
    #1;
    check("cyc_m_valid",    64'(m_valid),    64'(exp_q.size() != 0));
    check("cyc_m_data",     64'(m_data),     64'(exp_q.size() != 0 ? exp_q[0] : 32'd0));
    check("cyc_fifo_count", 64'(fifo_count), 64'(exp_q.size()));
    check("cyc_overflow",   64'(overflow),   64'(m_ovf));
    check("cyc_frame_err",  64'(frame_err),  64'(m_ferr));
    if (frame_err) ferr_pulses++;
    if (m_valid && m_ready) popped.push_back(m_data);
    for (int i = 0; i < 4; i++) begin
      if (mv[i]) begin
        mode_word[i] = md[i];
        mode_cnt[i]++;
      end
    end
  end

  // ---------------- SPI master tasks ----------------
  task automatic select(input bit mode_bus);
    if (mode_bus) cs_m = 1'b0; else cs_n = 1'b0;
    tick(4);
  endtask

  task automatic deselect(input bit mode_bus);
    if (mode_bus) cs_m = 1'b1; else cs_n = 1'b1;
    tick(6);
  endtask

  // Each bit: data set, then one full sclk pulse; data is held across both edges.
  task automatic send_bits(input logic [31:0] w, input int n, input bit msb);
    logic [31:0] v;
    v = w;
    for (int k = 0; k < n; k++) begin
      sdi = msb ? v[31 - k] : v[k];
      tick(3);
      sclk = 1'b1;
      tick(3);
      sclk = 1'b0;
      tick(3);
    end
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    tick(1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int f0;
    int base [4];
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; cs_m = 1'b1; sdi = 1'b0;
    m_ready = 1'b0; clr_err = 1'b0;
    tick(3);
    check("rst_m_valid",    64'(m_valid),    64'd0);
    check("rst_m_data",     64'(m_data),     64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_overflow",   64'(overflow),   64'd0);
    check("rst_frame_err",  64'(frame_err),  64'd0);
    rst_n = 1'b1;
    tick(4);

    // 1: single MSB-first word
    f0 = ferr_pulses;
    popped.delete();
    select(1'b0);
    send_bits(32'hDEADBEEF, 32, 1'b1);
    deselect(1'b0);
    check("t1_model_size", 64'(exp_q.size()), 64'd1);
    check("t1_model_head", 64'(exp_q[0]), 64'hDEADBEEF);
    check("t1_m_valid", 64'(m_valid), 64'd1);
    check("t1_m_data",  64'(m_data),  64'hDEADBEEF);
    check("t1_count",   64'(fifo_count), 64'd1);
    pop_one();
    check("t1_pops",      64'(popped.size()), 64'd1);
    check("t1_after_pop", 64'(fifo_count), 64'd0);
    check("t1_frame_err", 64'(ferr_pulses - f0), 64'd0);

    // 2: all four modes, LSB-first
    for (int i = 0; i < 4; i++) base[i] = mode_cnt[i];
    select(1'b1);
    send_bits(32'h12345678, 32, 1'b0);
    deselect(1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_mode%0d_words", i), 64'(mode_cnt[i] - base[i]), 64'd1);
      check($sformatf("t2_mode%0d_data", i),  64'(mode_word[i]), 64'h12345678);
    end

    // 3: three words in one frame, consumer always ready
    popped.delete();
    m_ready = 1'b1;
    select(1'b0);
    send_bits(32'h1, 32, 1'b1);
    send_bits(32'h2, 32, 1'b1);
    send_bits(32'h3, 32, 1'b1);
    deselect(1'b0);
    m_ready = 1'b0;
    tick(1);
    check("t3_pops", 64'(popped.size()), 64'd3);
    for (int i = 0; i < 3 && i < popped.size(); i++)
      check($sformatf("t3_pop%0d", i), 64'(popped[i]), 64'(i + 1));
    check("t3_count", 64'(fifo_count), 64'd0);

    // 4: five words into a four-entry FIFO with consumer stalled
    select(1'b0);
    for (int i = 1; i <= 5; i++) send_bits(32'(i), 32, 1'b1);
    deselect(1'b0);
    check("t4_count",    64'(fifo_count), 64'd4);
    check("t4_overflow", 64'(overflow),   64'd1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t4_head%0d", i), 64'(m_data), 64'(i));
      pop_one();
    end
    check("t4_empty",        64'(fifo_count), 64'd0);
    check("t4_ovf_sticky",   64'(overflow),   64'd1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(1);
    check("t4_ovf_cleared",  64'(overflow),   64'd0);

    // 5: partial frame of 13 bits, then a clean frame
    f0 = ferr_pulses;
    select(1'b0);
    send_bits(32'hFFFFFFFF, 13, 1'b1);
    deselect(1'b0);
    check("t5_frame_err", 64'(ferr_pulses - f0), 64'd1);
    check("t5_no_push",   64'(fifo_count), 64'd0);
    select(1'b0);
    send_bits(32'hCAFEF00D, 32, 1'b1);
    deselect(1'b0);
    check("t5_data",       64'(m_data), 64'hCAFEF00D);
    check("t5_count",      64'(fifo_count), 64'd1);
    check("t5_one_pulse",  64'(ferr_pulses - f0), 64'd1);
    pop_one();

    // 6: reset mid-word with two words queued
    f0 = ferr_pulses;
    select(1'b0);
    send_bits(32'h1A2B3C4D, 32, 1'b1);
    send_bits(32'h55AA55AA, 32, 1'b1);
    send_bits(32'h0F0F0F0F, 10, 1'b1);
    check("t6_queued", 64'(fifo_count), 64'd2);
    rst_n = 1'b0;
    tick(1);
    check("t6_m_valid",  64'(m_valid),    64'd0);
    check("t6_count",    64'(fifo_count), 64'd0);
    check("t6_overflow", 64'(overflow),   64'd0);
    cs_n = 1'b1; sclk = 1'b0; sdi = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    select(1'b0);
    send_bits(32'h0BADC0DE, 32, 1'b1);
    deselect(1'b0);
    check("t6_data",      64'(m_data), 64'h0BADC0DE);
    check("t6_count_new", 64'(fifo_count), 64'd1);
    check("t6_no_ferr",   64'(ferr_pulses - f0), 64'd0);
    pop_one();
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
